bcd_display_shifter: RTL and testbench
======================================

Name: bcd_display_shifter

Overview:
- Downstream consumer of the bcd_register digit chain (hh:mm:ss).
- On a refresh request, snapshots NUM_DIGITS BCD digits and converts each to a 7-segment+DP byte.
- Shifts the frame MSB-first into an external chain of 74HC595-style shift registers, then pulses the storage latch.
- Sits between the time-keeping registers and the chip output pins.

Parameters:
- NUM_DIGITS, 6, number of BCD digits per frame (frame = 8*NUM_DIGITS bits).
- CLK_DIV, 4, clk cycles per sclk half-period; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- refresh  input  1  frame request, sampled each clk; acted on only in IDLE.
- digits  input  4*NUM_DIGITS  packed BCD; digit i at [4i+3:4i]; digit NUM_DIGITS-1 is the leftmost (hour tens).
- dp_mask  input  NUM_DIGITS  decimal point enable per digit; bit i maps to digit i.
- sclk  output  1  serial shift clock to the external chain.
- sdata  output  1  serial data; stable while sclk is high.
- latch  output  1  storage-register latch strobe.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame has completed.

Behaviour:
- Reset (async, reset_n=0): state IDLE; sclk, sdata, latch, busy and done all 0; internal counters and snapshot cleared.
- Reset mid-frame: aborts immediately. No latch pulse is generated, so the external outputs keep the previous frame.
- States: IDLE -> SHIFT -> LATCH -> DONE -> IDLE.
- IDLE:
  - sclk=0, latch=0, busy=0.
  - If refresh=1 at an edge, capture digits and dp_mask into the snapshot and enter SHIFT. busy=1 from the next cycle.
- Segment encode, per digit byte {dp,g,f,e,d,c,b,a}, active high:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A-F encode as blank (segments 00); dp still applies.
  - Bit 7 = dp_mask[i].
- Frame order:
  - Byte for digit NUM_DIGITS-1 first, digit 0 last.
  - Each byte is sent MSB (dp) first.
  - Total 8*NUM_DIGITS bits.
- SHIFT, per bit:
  - sdata presents the bit with sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - sdata changes only on the cycle sclk falls, or on SHIFT entry.
  - The first bit is valid on the first SHIFT cycle.
- After the last bit's high phase: enter LATCH. sclk=0, latch=1 for exactly CLK_DIV cycles; sdata holds its last value.
- DONE (one cycle):
  - done=1, busy=0, latch=0.
  - DONE behaves as IDLE for refresh, so a refresh here is accepted, giving back-to-back frames.
  - Next state is IDLE, or SHIFT if refresh=1.
- Timing: busy high for 16*NUM_DIGITS*CLK_DIV + CLK_DIV cycles; done follows on the next cycle.
- refresh while busy: ignored, not queued.
- digits/dp_mask changes during a frame: no effect; the snapshot is used.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter widths: bit index ceil(log2(8*NUM_DIGITS)); divide counter ceil(log2(CLK_DIV+1)). Wrap-free; both are reset on SHIFT entry.

Test Plan (bench default NUM_DIGITS=6, CLK_DIV=2 unless stated):
- Reset: hold reset_n=0 for 3 cycles, then release with refresh=0. All outputs stay 0 and busy stays 0 for 20 cycles.
- Basic frame: digits=24'h123456, dp_mask=6'b000000, pulse refresh.
  - Serial capture on sclk rising edges is 06 5B 4F 66 6D 7D.
  - 48 sclk rising edges; latch high for 2 cycles after the last edge.
  - busy high for 194 cycles; done is a single pulse on the following cycle.
- DP and blanking: digits=24'hF9000A, dp_mask=6'b010100. Bytes are 00 EF 3F BF 3F 00.
- Busy/ignore and snapshot: start a frame with 24'h000000, then 10 cycles in change digits to 24'h999999 and pulse refresh.
  - Exactly one frame of six 3F bytes is sent.
  - No second frame follows.
- Back-to-back: hold refresh=1 continuously. Frames repeat with busy low only during each done cycle; done pulses every 195 cycles.
- Reset mid-frame: assert reset_n=0 after 20 bits, then release.
  - latch never pulses for the aborted frame; outputs return to 0 asynchronously.
  - A new refresh produces a complete, correct frame.
  - Repeat with CLK_DIV=1: busy is 97 cycles.

Source files
------------

// File: rtl/bcd_display_shifter.sv
// Snapshots a BCD time frame, encodes each digit to 7-segment+DP and shifts it
// MSB-first into an external 74HC595-style chain, then strobes the storage latch.
module bcd_display_shifter #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    refresh,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic                    sclk,
    output logic                    sdata,
    output logic                    latch,
    output logic                    busy,
    output logic                    done
);

    localparam int FRAME_BITS = 8 * NUM_DIGITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    state_t state, state_next;

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [BIT_W-1:0]        bit_idx;
    logic [DIV_W-1:0]        div_cnt;
    logic [FRAME_BITS-1:0]   frame;
    logic [FRAME_BITS-1:0]   serial;   // serial[k] is the k-th bit on the wire
    logic                    bit_last;
    logic                    div_last;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_encode = 7'h3F;
            4'd1:    seg_encode = 7'h06;
            4'd2:    seg_encode = 7'h5B;
            4'd3:    seg_encode = 7'h4F;
            4'd4:    seg_encode = 7'h66;
            4'd5:    seg_encode = 7'h6D;
            4'd6:    seg_encode = 7'h7D;
            4'd7:    seg_encode = 7'h07;
            4'd8:    seg_encode = 7'h7F;
            4'd9:    seg_encode = 7'h6F;
            default: seg_encode = 7'h00;
        endcase
    endfunction

    always_comb begin
        frame  = '0;
        serial = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            frame[8*i +: 8] = {snap_dp[i], seg_encode(snap_digits[4*i +: 4])};
        end
        for (int k = 0; k < FRAME_BITS; k++) begin
            serial[k] = frame[FRAME_BITS-1-k];
        end
    end

    assign bit_last = (bit_idx == BIT_LAST);
    assign div_last = (div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (refresh) state_next = SHIFT;
            SHIFT:   if (div_last && sclk && bit_last) state_next = LATCH;
            LATCH:   if (div_last) state_next = DONE;
            DONE:    state_next = refresh ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from state_next so they line up with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            latch       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            bit_idx     <= '0;
            div_cnt     <= '0;
        end else begin
            busy  <= (state_next == SHIFT) || (state_next == LATCH);
            latch <= (state_next == LATCH);
            done  <= (state_next == DONE);
            case (state)
                IDLE, DONE: begin
                    if (refresh) begin
                        snap_digits <= digits;
                        snap_dp     <= dp_mask;
                        bit_idx     <= '0;
                        div_cnt     <= '0;
                        sclk        <= 1'b0;
                        // First wire bit is the leftmost digit's DP.
                        sdata       <= dp_mask[NUM_DIGITS-1];
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (!bit_last) begin
                                bit_idx <= bit_idx + 1'b1;
                                sdata   <= serial[bit_idx + 1'b1];
                            end
                        end else begin
                            sclk <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_shifter.sv
// Self-checking bench: table vectors, random frames vs a reference model, and
// multi-cycle sequences (ignore-while-busy, back-to-back, mid-frame reset).
module tb_bcd_display_shifter;

    localparam int ND = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          refresh;
    logic [23:0]   digits;
    logic [5:0]    dp_mask;
    logic          sclk_a, sdata_a, latch_a, busy_a, done_a;
    logic          sclk_b, sdata_b, latch_b, busy_b, done_b;

    bcd_display_shifter #(.NUM_DIGITS(ND), .CLK_DIV(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .refresh(refresh), .digits(digits), .dp_mask(dp_mask),
        .sclk(sclk_a), .sdata(sdata_a), .latch(latch_a), .busy(busy_a), .done(done_a)
    );

    bcd_display_shifter #(.NUM_DIGITS(ND), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .refresh(refresh), .digits(digits), .dp_mask(dp_mask),
        .sclk(sclk_b), .sdata(sdata_b), .latch(latch_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Monitor selects which instance is under observation.
    logic       sel;
    int         cur_div;
    logic       m_sclk, m_sdata, m_latch, m_busy, m_done;
    logic [4:0] mon;
    assign m_sclk  = sel ? sclk_b  : sclk_a;
    assign m_sdata = sel ? sdata_b : sdata_a;
    assign m_latch = sel ? latch_b : latch_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign mon     = {m_sclk, m_sdata, m_latch, m_busy, m_done};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: table lookup from the segment chart, digit N-1 leftmost.
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [47:0] model(input logic [23:0] d, input logic [5:0] m);
        logic [47:0] f;
        int          nib;
        f = '0;
        for (int i = 0; i < ND; i++) begin
            nib = int'(d[4*i +: 4]);
            f[8*i +: 8] = {m[i], (nib < 10) ? seg_tab[nib] : 7'h00};
        end
        return f;
    endfunction

    // Capture results of one frame, sampled on negedges.
    logic cap_bits[$];
    int   busy_cnt, latch_cnt;
    logic latch_early, done_seen;

    task automatic collect();
        logic prev;
        prev = 1'b0;
        cap_bits.delete();
        busy_cnt = 0; latch_cnt = 0; latch_early = 1'b0; done_seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (m_busy) busy_cnt++;
            if (m_sclk && !prev) cap_bits.push_back(m_sdata);
            prev = m_sclk;
            if (m_latch) begin
                latch_cnt++;
                if (cap_bits.size() != 8*ND) latch_early = 1'b1;
            end
            if (m_done) begin
                done_seen = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic verify_frame(input string name, input logic [47:0] exp);
        logic [7:0] got;
        check({name, " bits"}, 64'(cap_bits.size()), 64'(8*ND));
        for (int b = 0; b < ND; b++) begin
            got = 8'h00;
            if (cap_bits.size() >= 8*b + 8)
                for (int j = 0; j < 8; j++) got = {got[6:0], cap_bits[8*b+j]};
            check($sformatf("%s byte%0d", name, b), 64'(got), 64'(exp[47-8*b -: 8]));
        end
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(16*ND*cur_div + cur_div));
        check({name, " latch_cycles"}, 64'(latch_cnt), 64'(cur_div));
        check({name, " latch_before_last_edge"}, 64'(latch_early), 64'(0));
        check({name, " done_seen"}, 64'(done_seen), 64'(1));
        @(negedge clk);
        check({name, " done_single"}, 64'({m_done, m_busy}), 64'(0));
    endtask

    task automatic run_frame(input string name, input logic [23:0] d, input logic [5:0] m,
                             input logic [47:0] exp);
        @(negedge clk);
        digits = d; dp_mask = m; refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        collect();
        verify_frame(name, exp);
    endtask

    task automatic mid_reset(input string name);
        int   edges;
        logic prev, latch_seen;
        @(negedge clk);
        digits = 24'h135790; dp_mask = 6'b100001; refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        edges = 0; prev = 1'b0; latch_seen = 1'b0;
        for (int c = 0; c < 1000 && edges < 20; c++) begin
            if (m_sclk && !prev) edges++;
            prev = m_sclk;
            if (m_latch) latch_seen = 1'b1;
            if (edges < 20) @(negedge clk);
        end
        check({name, " edges_before_abort"}, 64'(edges), 64'(20));
        reset_n = 1'b0;
        #1;
        check({name, " async_clear"}, 64'(mon), 64'(0));
        repeat (2) @(negedge clk);
        check({name, " no_latch"}, 64'(latch_seen || m_latch), 64'(0));
        reset_n = 1'b1;
        run_frame({name, " after"}, 24'h204859, 6'b000110, model(24'h204859, 6'b000110));
    endtask

    typedef struct {
        logic [23:0] d;
        logic [5:0]  m;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[5];
    int   idle_busy, last_done, gaps_bad, idle_bad, ndone;
    logic [23:0] rd;
    logic [5:0]  rm;

    initial begin
        vecs[0] = '{24'h123456, 6'b000000, 48'h065B4F666D7D};
        vecs[1] = '{24'hF9000A, 6'b010100, 48'h00EF3FBF3F00};
        vecs[2] = '{24'h000000, 6'b000000, 48'h3F3F3F3F3F3F};
        vecs[3] = '{24'h789012, 6'b111111, 48'h87FFEFBF86DB};
        vecs[4] = '{24'hBCDE45, 6'b000001, 48'h0000000066ED};

        sel = 1'b0; cur_div = 2;
        reset_n = 1'b0; refresh = 1'b0; digits = '0; dp_mask = '0;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", 64'(mon), 64'(0));
        end
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", c), 64'(mon), 64'(0));
        end

        for (int v = 0; v < 5; v++)
            run_frame($sformatf("vec%0d", v), vecs[v].d, vecs[v].m, vecs[v].exp);

        for (int r = 0; r < 6; r++) begin
            rd = 24'($urandom);
            rm = 6'($urandom);
            run_frame($sformatf("rand%0d", r), rd, rm, model(rd, rm));
        end

        // Refresh while busy is ignored and the snapshot is used.
        @(negedge clk);
        digits = 24'h000000; dp_mask = 6'b000000; refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        fork
            collect();
            begin
                repeat (10) @(negedge clk);
                digits = 24'h999999; refresh = 1'b1;
                @(negedge clk);
                refresh = 1'b0;
            end
        join
        verify_frame("ignore", 48'h3F3F3F3F3F3F);
        idle_busy = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (m_busy || m_latch || m_done) idle_busy++;
        end
        check("no_second_frame", 64'(idle_busy), 64'(0));

        // Back-to-back frames with refresh held high.
        @(negedge clk);
        digits = 24'h123456; refresh = 1'b1;
        @(negedge clk);
        last_done = -1; gaps_bad = 0; idle_bad = 0; ndone = 0;
        for (int c = 0; c < 600; c++) begin
            if (m_done) begin
                if (last_done >= 0 && c - last_done != 195) gaps_bad++;
                last_done = c;
                ndone++;
            end
            if (!m_busy && !m_done) idle_bad++;
            @(negedge clk);
        end
        refresh = 1'b0;
        check("b2b_done_count", 64'(ndone), 64'(3));
        check("b2b_done_period", 64'(gaps_bad), 64'(0));
        check("b2b_idle_gap", 64'(idle_bad), 64'(0));
        repeat (300) @(negedge clk);

        mid_reset("abort_div2");

        sel = 1'b1; cur_div = 1;
        repeat (300) @(negedge clk);
        mid_reset("abort_div1");
        rd = 24'($urandom);
        rm = 6'($urandom);
        run_frame("div1_rand", rd, rm, model(rd, rm));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
